// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode and FSM state encodings for the ALU operation sequencer.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_MUL = 3'd6,
    OP_DIV = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GOT_A = 3'd1,
    S_READY = 3'd2,
    S_EXEC  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Ops that take one cycle per operand bit in the shift-add/subtract unit.
  function automatic logic is_iter(op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Pushbutton-facing bus of the ALU sequencer: entry value, control pulses, result and flags.
interface alu_op_sequencer_if #(parameter int W = 8);
  import alu_pkg::*;

  // load/go/clr are single-cycle pulses with no back-pressure; result_valid stays high
  // (with result and flags stable) until the next load or clr.
  logic [W-1:0]   entry_val;
  logic           load;
  logic           go;
  logic           clr;
  op_e            op_sel;
  logic [2*W-1:0] result;
  logic           result_valid;
  logic           busy;
  logic           flag_zero;
  logic           flag_carry;
  logic           flag_err;
  state_e         state;

  modport master (
    output entry_val, load, go, clr, op_sel,
    input  result, result_valid, busy, flag_zero, flag_carry, flag_err, state
  );

  modport slave (
    input  entry_val, load, go, clr, op_sel,
    output result, result_valid, busy, flag_zero, flag_carry, flag_err, state
  );
endinterface

// File: rtl/alu_op_sequencer_muldiv.sv
// Iterative unit: radix-2 shift-add multiply and restoring divide, one operand bit per cycle.
module seq_muldiv #(parameter int W = 8) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           abort,
  input  logic           start,
  input  logic           is_div,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder
);
  localparam int CW = $clog2(W);

  logic           run_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] acc_q, mcand_q, acc_n;
  logic [W-1:0]   mplier_q;
  logic [W-1:0]   rem_q, quo_q, dvsr_q, rem_n, quo_n;
  logic [W:0]     trial, diff;

  // Outputs are the post-step values so the parent can capture them on the final edge.
  always_comb begin
    acc_n = acc_q + (mplier_q[0] ? mcand_q : '0);
    trial = {rem_q, quo_q[W-1]};
    diff  = trial - {1'b0, dvsr_q};
    if (!diff[W]) begin
      rem_n = diff[W-1:0];
      quo_n = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_n = trial[W-1:0];
      quo_n = {quo_q[W-2:0], 1'b0};
    end
  end

  assign done      = run_q && (cnt_q == CW'(W-1));
  assign product   = acc_n;
  assign quotient  = quo_n;
  assign remainder = rem_n;

  always_ff @(posedge clk) begin
    if (!rstn || abort) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
    end else if (start) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= is_div ? '0 : {{W{1'b0}}, a};
      mplier_q <= is_div ? '0 : b;
      rem_q    <= '0;
      quo_q    <= is_div ? a : '0;
      dvsr_q   <= is_div ? b : '0;
    end else if (run_q) begin
      acc_q    <= acc_n;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      rem_q    <= rem_n;
      quo_q    <= quo_n;
      cnt_q    <= cnt_q + 1'b1;
      if (done) run_q <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Operand/opcode sequencer: load A, load B, go executes; result and flags held until load or clr.
module alu_op_sequencer #(parameter int W = 8) (
  input logic               clk,
  input logic               rstn,
  alu_op_sequencer_if.slave bus
);
  import alu_pkg::*;

  localparam int SHW = $clog2(W);

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, b_q;
  op_e            op_q;
  logic [2*W-1:0] result_q, exec_result;
  logic           valid_q, zero_q, carry_q, err_q, exec_carry;
  logic           md_start, md_done, div_by_zero, exec_finish;
  logic [2*W-1:0] md_product;
  logic [W-1:0]   md_quot, md_rem;

  assign div_by_zero = (op_q == OP_DIV) && (b_q == '0);
  assign exec_finish = (state_q == S_EXEC) && (!is_iter(op_q) || div_by_zero || md_done);

  seq_muldiv #(.W(W)) u_muldiv (
    .clk       (clk),
    .rstn      (rstn),
    .abort     (bus.clr),
    .start     (md_start),
    .is_div    (bus.op_sel == OP_DIV),
    .a         (a_q),
    .b         (b_q),
    .done      (md_done),
    .product   (md_product),
    .quotient  (md_quot),
    .remainder (md_rem)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // clr beats load beats go; the case order below encodes that priority.
  always_comb begin
    state_d  = state_q;
    md_start = 1'b0;
    if (bus.clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.load) state_d = S_GOT_A;
        S_GOT_A: if (bus.load) state_d = S_READY;
        S_READY: begin
          if (bus.load) begin
            state_d = S_READY;
          end else if (bus.go) begin
            state_d  = S_EXEC;
            md_start = is_iter(bus.op_sel) && !((bus.op_sel == OP_DIV) && (b_q == '0));
          end
        end
        S_EXEC:  if (exec_finish) state_d = S_DONE;
        S_DONE:  if (bus.load) state_d = S_GOT_A;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    exec_result = '0;
    exec_carry  = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_result[W:0] = {1'b0, a_q} + {1'b0, b_q};
        exec_carry       = exec_result[W];
      end
      OP_SUB: begin
        exec_result[W-1:0] = a_q - b_q;
        exec_carry         = (a_q < b_q);
      end
      OP_AND:  exec_result[W-1:0] = a_q & b_q;
      OP_OR:   exec_result[W-1:0] = a_q | b_q;
      OP_XOR:  exec_result[W-1:0] = a_q ^ b_q;
      OP_SHL:  exec_result = {{W{1'b0}}, a_q} << b_q[SHW-1:0];
      OP_MUL:  exec_result = md_product;
      OP_DIV:  exec_result = div_by_zero ? '1 : {md_rem, md_quot};
      default: exec_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn || bus.clr) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.load) a_q <= bus.entry_val;
        S_GOT_A: if (bus.load) b_q <= bus.entry_val;
        S_READY: begin
          if (bus.load)    b_q  <= bus.entry_val;
          else if (bus.go) op_q <= bus.op_sel;
        end
        S_EXEC: begin
          if (exec_finish) begin
            result_q <= exec_result;
            valid_q  <= 1'b1;
            zero_q   <= (exec_result == '0);
            carry_q  <= exec_carry;
            err_q    <= div_by_zero;
          end
        end
        S_DONE: begin
          if (bus.load) begin
            a_q      <= bus.entry_val;
            result_q <= '0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.busy         = (state_q == S_EXEC);
  assign bus.flag_zero    = zero_q;
  assign bus.flag_carry   = carry_q;
  assign bus.flag_err     = err_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and randomized checks of the ALU sequencer against an arithmetic reference model.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  alu_op_sequencer_if #(.W(W)) bus ();

  alu_op_sequencer #(.W(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_load(input logic [W-1:0] v);
    bus.entry_val = v;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  task automatic pulse_go(input op_e op);
    bus.op_sel = op;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
  endtask

  // Reference model: plain arithmetic on the operands.
  task automatic model(input op_e op, input int a, input int b,
                       output logic [15:0] r, output logic c, output logic z, output logic e);
    int v;
    c = 1'b0;
    e = 1'b0;
    case (op)
      OP_ADD: begin v = a + b; c = (v > 255); end
      OP_SUB: begin v = (a - b + 256) % 256; c = (a < b); end
      OP_AND: v = a & b;
      OP_OR:  v = a | b;
      OP_XOR: v = a ^ b;
      OP_SHL: v = a * (2 ** (b % 8));
      OP_MUL: v = a * b;
      default: begin
        if (b == 0) begin v = 65535; e = 1'b1; end
        else v = (a % b) * 256 + (a / b);
      end
    endcase
    r = 16'(v);
    z = (v == 0);
  endtask

  // From S_READY: pulse go, then measure latency/busy and check the held result.
  task automatic finish_op(input string tag, input op_e op, input int b,
                           input logic [15:0] er, input logic ec, input logic ez, input logic ee);
    int lat, busy_cnt, exp_lat;
    exp_lat = ((op == OP_MUL) || (op == OP_DIV && b != 0)) ? W : 1;
    pulse_go(op);
    check({tag, "_valid_at_go"}, 32'(bus.result_valid), 32'd0);
    lat = 0;
    busy_cnt = 0;
    while (!bus.result_valid && lat < 20) begin
      if (bus.busy) busy_cnt++;
      tick();
      lat++;
    end
    check({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    check({tag, "_result"}, 32'(bus.result), 32'(er));
    check({tag, "_carry"}, 32'(bus.flag_carry), 32'(ec));
    check({tag, "_zero"}, 32'(bus.flag_zero), 32'(ez));
    check({tag, "_err"}, 32'(bus.flag_err), 32'(ee));
    check({tag, "_state"}, 32'(bus.state), 32'(S_DONE));
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input op_e op,
                        input logic [15:0] er, input logic ec, input logic ez, input logic ee);
    pulse_load(a);
    pulse_load(b);
    finish_op(tag, op, int'(b), er, ec, ez, ee);
  endtask

  initial begin
    logic [15:0] mr;
    logic mc, mz, me;
    logic [W-1:0] ra, rb;
    op_e rop;

    bus.entry_val = '0;
    bus.load = 1'b0;
    bus.go = 1'b0;
    bus.clr = 1'b0;
    bus.op_sel = OP_ADD;

    // 1. reset
    rstn = 1'b0;
    tick();
    tick();
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_flags", {29'd0, bus.flag_zero, bus.flag_carry, bus.flag_err}, 32'd0);
    check("rst_state", 32'(bus.state), 32'(S_IDLE));
    rstn = 1'b1;
    run_op("add_5_3", 8'h05, 8'h03, OP_ADD, 16'h0008, 1'b0, 1'b0, 1'b0);

    // 2. carry and borrow
    pulse_clr();
    check("clr_state", 32'(bus.state), 32'(S_IDLE));
    check("clr_result", 32'(bus.result), 32'd0);
    run_op("add_carry", 8'hFF, 8'h01, OP_ADD, 16'h0100, 1'b1, 1'b0, 1'b0);
    pulse_clr();
    run_op("sub_borrow", 8'h03, 8'h05, OP_SUB, 16'h00FE, 1'b1, 1'b0, 1'b0);
    pulse_clr();
    run_op("sub_zero", 8'h05, 8'h05, OP_SUB, 16'h0000, 1'b0, 1'b1, 1'b0);

    // 3. iterative ops
    pulse_clr();
    run_op("mul_ff", 8'hFF, 8'hFF, OP_MUL, 16'hFE01, 1'b0, 1'b0, 1'b0);
    pulse_clr();
    run_op("div_64_7", 8'h64, 8'h07, OP_DIV, 16'h020E, 1'b0, 1'b0, 1'b0);
    pulse_clr();
    run_op("div_zero", 8'h10, 8'h00, OP_DIV, 16'hFFFF, 1'b0, 1'b0, 1'b1);

    // 4. ignored and priority pulses
    pulse_clr();
    pulse_go(OP_ADD);
    check("go_idle_state", 32'(bus.state), 32'(S_IDLE));
    check("go_idle_valid", 32'(bus.result_valid), 32'd0);
    pulse_load(8'h03);
    pulse_go(OP_ADD);
    check("go_gota_state", 32'(bus.state), 32'(S_GOT_A));
    pulse_load(8'h05);
    pulse_go(OP_MUL);
    tick();
    pulse_load(8'h77);
    check("load_exec_state", 32'(bus.state), 32'(S_EXEC));
    for (int i = 0; i < 20 && !bus.result_valid; i++) tick();
    check("load_exec_valid", 32'(bus.result_valid), 32'd1);
    check("load_exec_result", 32'(bus.result), 32'h000F);
    pulse_clr();
    pulse_load(8'h02);
    pulse_load(8'h03);
    bus.entry_val = 8'h04;
    bus.load = 1'b1;
    bus.go = 1'b1;
    bus.op_sel = OP_ADD;
    tick();
    bus.load = 1'b0;
    bus.go = 1'b0;
    check("load_go_state", 32'(bus.state), 32'(S_READY));
    check("load_go_busy", 32'(bus.busy), 32'd0);
    finish_op("load_go_add", OP_ADD, 4, 16'h0006, 1'b0, 1'b0, 1'b0);

    // 5. abort mid-MUL
    pulse_clr();
    pulse_load(8'h09);
    pulse_load(8'h07);
    pulse_go(OP_MUL);
    tick();
    tick();
    tick();
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    pulse_clr();
    check("abort_state", 32'(bus.state), 32'(S_IDLE));
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_valid", 32'(bus.result_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    run_op("post_abort_mul", 8'h09, 8'h07, OP_MUL, 16'h003F, 1'b0, 1'b0, 1'b0);

    // 6. re-entry from S_DONE
    pulse_load(8'h02);
    check("reentry_valid", 32'(bus.result_valid), 32'd0);
    check("reentry_state", 32'(bus.state), 32'(S_GOT_A));
    check("reentry_flags", {29'd0, bus.flag_zero, bus.flag_carry, bus.flag_err}, 32'd0);
    pulse_load(8'h03);
    finish_op("reentry_shl", OP_SHL, 3, 16'h0010, 1'b0, 1'b0, 1'b0);

    // randomized transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      pulse_clr();
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      rop = op_e'(3'($urandom_range(0, 7)));
      model(rop, int'(ra), int'(rb), mr, mc, mz, me);
      run_op($sformatf("rnd%0d_%s", n, rop.name()), ra, rb, rop, mr, mc, mz, me);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
